hc_csr_regfile: RTL and testbench
=================================

Name: hc_csr_regfile

Overview:
Parametrised MMIO control/status register file for HardCloud accelerators. Generalises the fixed 2-buffer CSR decode to NUM_BUFFERS address/size pairs. Adds a command-driven control state machine, configuration tracking, and 1-cycle MMIO read-back. Sits between the CCI-P MMIO receive channel and the accelerator datapath (read/write engines).

Parameters:
NUM_BUFFERS, 4, number of buffer address/size register pairs (1..8)
ADDR_W, 42, buffer address width in cache lines
SIZE_W, 32, buffer size width (bytes)
BUF_BASE, 16'h120, byte offset of buffer 0 address register; buffer i address at BUF_BASE+16*i, size at BUF_BASE+16*i+8

Ports:
clk  in  1  accelerator clock
rst_n  in  1  asynchronous active-low reset
mmio_wr_valid  in  1  MMIO write strobe
mmio_rd_valid  in  1  MMIO read strobe
mmio_addr  in  16  MMIO address in 4-byte units (byte offset >> 2)
mmio_tid  in  9  MMIO transaction id
mmio_wr_data  in  64  MMIO write data
rd_rsp_valid  out  1  read response valid
rd_rsp_tid  out  9  echoed tid
rd_rsp_data  out  64  read data
dsm_base  out  64  DSM base address (byte)
buf_addr  out  NUM_BUFFERS*ADDR_W  buffer addresses, buffer i at [i*ADDR_W +: ADDR_W]
buf_size  out  NUM_BUFFERS*SIZE_W  buffer sizes, same packing
acc_soft_reset  out  1  accelerator held in reset
acc_start  out  1  one-cycle start pulse
acc_running  out  1  high in S_RUN
acc_done  in  1  accelerator completion (level or pulse)

Behaviour:
- Reset values: all registers 0, state S_RESET, acc_soft_reset=1, acc_start=0, acc_running=0, rd_rsp_valid=0, rd_rsp_tid=0, rd_rsp_data=0, cfg mask=0.
- Map (byte offsets): 0x100 STATUS (RO), 0x110 DSM_BASE (RW, 64b), 0x118 CONTROL (WO, data[31:0]), buffer regs per BUF_BASE. Buffer decode: byte offset in [BUF_BASE, BUF_BASE+16*NUM_BUFFERS-8] with bits[2:0]=0; index = (offset-BUF_BASE)>>4; size select = offset bit 3 (mmio_addr[1]). All other addresses: writes ignored, reads return 0.
- Address write captures mmio_wr_data[ADDR_W-1:0] (software writes byte address >> 6); size write captures [SIZE_W-1:0]. Each write sets cfg bit (2*i for address, 2*i+1 for size). Outputs registered; visible the cycle after the write.
- Control FSM (commands in CONTROL write; undefined values ignored):
  0x0 -> S_RESET from any state.
  0x1 -> S_IDLE from S_RESET, S_STOP, S_DONE.
  0x3 -> S_RUN from S_IDLE only; acc_start pulses high exactly the first cycle in S_RUN.
  0x7 -> S_STOP from S_RUN.
  S_RUN with acc_done=1 -> S_DONE next cycle. A command write the same cycle takes priority over acc_done.
  acc_soft_reset=1 only in S_RESET; acc_running=1 only in S_RUN.
  Entering S_RESET clears the cfg mask; buffer and DSM contents are retained.
- Reads: rd_rsp_valid asserts exactly 1 cycle after mmio_rd_valid, with the tid echoed. Read and write in the same cycle to the same register return the pre-write value. Reads are accepted every cycle with no back-pressure.
- STATUS: [2:0] state (RESET=0, IDLE=1, RUN=2, STOP=3, DONE=4), [3] start-rejected sticky, [31:16] cfg mask (zero-extended).
- Asynchronous reset mid-run forces every output to its reset value immediately; any pending read response is dropped.

Optional Feature:
HC_CFG_CHECK_EN: when defined, 0x3 in S_IDLE is accepted only if every cfg bit (2*NUM_BUFFERS bits) is set. Otherwise the state stays S_IDLE, there is no acc_start, and STATUS[3] is set; STATUS[3] clears on entry to S_RESET. When undefined, 0x3 from S_IDLE is always accepted and STATUS[3] reads 0.

Test Plan:
- Reset, then read 0x100 with tid 0x55 -> one cycle later rd_rsp_valid=1, tid=0x55, data=0, acc_soft_reset=1.
- With NUM_BUFFERS=4: write 0x150=0x1234, 0x158=4096 -> buf_addr[3]=0x1234, buf_size[3]=4096, STATUS[31:16]=0x00C0. Write 0x160 -> no register changes.
- Control sequence 0x1, 0x3 -> acc_start high exactly one cycle, acc_running=1. acc_done=1 -> STATUS[2:0]=4. Control 0x0 -> acc_soft_reset=1, cfg mask 0.
- HC_CFG_CHECK_EN defined, only buffer 0 configured, control 0x1 then 0x3 -> no acc_start, STATUS[2:0]=1, STATUS[3]=1. Configure all buffers, control 0x3 -> S_RUN.
- Same-cycle write 0x110=0xAAAA and read 0x110 (old value 0x5555) -> response 0x5555; the next read returns 0xAAAA.
- In S_RUN, same-cycle control 0x7 and acc_done=1 -> state S_STOP. Deassert rst_n mid-run -> acc_running=0 and acc_soft_reset=1 without waiting for a clock edge.

Source files
------------

// File: rtl/hc_csr_regfile.sv
// MMIO control/status register file: DSM base, NUM_BUFFERS address/size pairs, control FSM, 1-cycle read-back.
// Define HC_CFG_CHECK_EN to refuse the run command until every buffer register has been written.
module hc_csr_regfile #(
    parameter int          NUM_BUFFERS = 4,
    parameter int          ADDR_W      = 42,
    parameter int          SIZE_W      = 32,
    parameter logic [15:0] BUF_BASE    = 16'h120
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          mmio_wr_valid,
    input  logic                          mmio_rd_valid,
    input  logic [15:0]                   mmio_addr,
    input  logic [8:0]                    mmio_tid,
    input  logic [63:0]                   mmio_wr_data,
    output logic                          rd_rsp_valid,
    output logic [8:0]                    rd_rsp_tid,
    output logic [63:0]                   rd_rsp_data,
    output logic [63:0]                   dsm_base,
    output logic [NUM_BUFFERS*ADDR_W-1:0] buf_addr,
    output logic [NUM_BUFFERS*SIZE_W-1:0] buf_size,
    output logic                          acc_soft_reset,
    output logic                          acc_start,
    output logic                          acc_running,
    input  logic                          acc_done
);

    localparam logic [2:0] S_RESET = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int          CFG_W  = 2 * NUM_BUFFERS;
    localparam int          IDX_W  = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1;
    localparam logic [17:0] BUF_LO = {2'b00, BUF_BASE};
    localparam logic [17:0] BUF_HI = BUF_LO + 18'(16 * NUM_BUFFERS - 8);

    logic [2:0]        state_q, state_d;
    logic              rej_q, rej_d;
    logic [CFG_W-1:0]  cfg_q, cfg_d;
    logic              start_q, start_d;
    logic              cmd_taken;
    logic [63:0]       dsm_q;
    logic [ADDR_W-1:0] buf_addr_q [NUM_BUFFERS];
    logic [SIZE_W-1:0] buf_size_q [NUM_BUFFERS];
    logic              rsp_valid_q;
    logic [8:0]        rsp_tid_q;
    logic [63:0]       rsp_data_q, rd_data_d;

    logic [17:0]      byte_off, buf_rel;
    logic [IDX_W-1:0] buf_idx;
    logic             hit_status, hit_dsm, hit_ctrl, hit_buf, wr_buf;
    logic [31:0]      cmd;
    logic             unused_bits;

    assign byte_off    = {mmio_addr, 2'b00};
    assign buf_rel     = byte_off - BUF_LO;
    assign buf_idx     = buf_rel[4 +: IDX_W];
    assign hit_status  = (byte_off == 18'h100);
    assign hit_dsm     = (byte_off == 18'h110);
    assign hit_ctrl    = (byte_off == 18'h118);
    assign hit_buf     = (byte_off >= BUF_LO) && (byte_off <= BUF_HI) && !mmio_addr[0];
    assign wr_buf      = mmio_wr_valid && hit_buf;
    assign cmd         = mmio_wr_data[31:0];
    assign unused_bits = ^{buf_rel[3:0], buf_rel[17:4+IDX_W]};

    // An accepted command outranks acc_done in the same cycle.
    always_comb begin
        state_d   = state_q;
        rej_d     = rej_q;
        cfg_d     = cfg_q;
        cmd_taken = 1'b0;
        for (int i = 0; i < NUM_BUFFERS; i++) begin
            if (wr_buf && buf_idx == IDX_W'(i)) begin
                if (mmio_addr[1]) cfg_d[2*i+1] = 1'b1;
                else              cfg_d[2*i]   = 1'b1;
            end
        end
        if (mmio_wr_valid && hit_ctrl) begin
            case (cmd)
                32'h0: begin
                    state_d   = S_RESET;
                    cfg_d     = '0;
                    rej_d     = 1'b0;
                    cmd_taken = 1'b1;
                end
                32'h1: if (state_q == S_RESET || state_q == S_STOP || state_q == S_DONE) begin
                    state_d   = S_IDLE;
                    cmd_taken = 1'b1;
                end
                32'h3: if (state_q == S_IDLE) begin
`ifdef HC_CFG_CHECK_EN
                    if (&cfg_q) state_d = S_RUN;
                    else        rej_d   = 1'b1;
`else
                    state_d = S_RUN;
`endif
                    cmd_taken = 1'b1;
                end
                32'h7: if (state_q == S_RUN) begin
                    state_d   = S_STOP;
                    cmd_taken = 1'b1;
                end
                default: ;
            endcase
        end
        if (!cmd_taken && state_q == S_RUN && acc_done) state_d = S_DONE;
        start_d = (state_d == S_RUN) && (state_q != S_RUN);
    end

    // Read data comes from current register contents, so a same-cycle write is not visible.
    always_comb begin
        rd_data_d = '0;
        if (hit_status) begin
            rd_data_d = {32'b0, 16'(cfg_q), 12'b0, rej_q, state_q};
        end else if (hit_dsm) begin
            rd_data_d = dsm_q;
        end else if (hit_buf) begin
            for (int i = 0; i < NUM_BUFFERS; i++) begin
                if (buf_idx == IDX_W'(i)) begin
                    rd_data_d = mmio_addr[1] ? 64'(buf_size_q[i]) : 64'(buf_addr_q[i]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RESET;
            rej_q       <= 1'b0;
            cfg_q       <= '0;
            start_q     <= 1'b0;
            dsm_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_tid_q   <= '0;
            rsp_data_q  <= '0;
            for (int i = 0; i < NUM_BUFFERS; i++) begin
                buf_addr_q[i] <= '0;
                buf_size_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            rej_q       <= rej_d;
            cfg_q       <= cfg_d;
            start_q     <= start_d;
            rsp_valid_q <= mmio_rd_valid;
            if (mmio_rd_valid) begin
                rsp_tid_q  <= mmio_tid;
                rsp_data_q <= rd_data_d;
            end
            if (mmio_wr_valid && hit_dsm) dsm_q <= mmio_wr_data;
            for (int i = 0; i < NUM_BUFFERS; i++) begin
                if (wr_buf && buf_idx == IDX_W'(i)) begin
                    if (mmio_addr[1]) buf_size_q[i] <= mmio_wr_data[SIZE_W-1:0];
                    else              buf_addr_q[i] <= mmio_wr_data[ADDR_W-1:0];
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_BUFFERS; g++) begin : g_pack
            assign buf_addr[g*ADDR_W +: ADDR_W] = buf_addr_q[g];
            assign buf_size[g*SIZE_W +: SIZE_W] = buf_size_q[g];
        end
    endgenerate

    assign rd_rsp_valid   = rsp_valid_q;
    assign rd_rsp_tid     = rsp_tid_q;
    assign rd_rsp_data    = rsp_data_q;
    assign dsm_base       = dsm_q;
    assign acc_soft_reset = (state_q == S_RESET);
    assign acc_running    = (state_q == S_RUN);
    assign acc_start      = start_q;

endmodule

// File: tb/tb_hc_csr_regfile.sv
// Bench for hc_csr_regfile (NUM_BUFFERS=4): register table, control sequences, async reset.
module tb_hc_csr_regfile;

  localparam int NB = 4;
  localparam int AW = 42;
  localparam int SW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mmio_wr_valid = 1'b0;
  logic          mmio_rd_valid = 1'b0;
  logic [15:0]   mmio_addr = '0;
  logic [8:0]    mmio_tid = '0;
  logic [63:0]   mmio_wr_data = '0;
  logic          rd_rsp_valid;
  logic [8:0]    rd_rsp_tid;
  logic [63:0]   rd_rsp_data;
  logic [63:0]   dsm_base;
  logic [NB*AW-1:0] buf_addr;
  logic [NB*SW-1:0] buf_size;
  logic          acc_soft_reset;
  logic          acc_start;
  logic          acc_running;
  logic          acc_done = 1'b0;

  int n_compared = 0;
  int n_mismatched = 0;
  logic [72:0] exp_q[$];
  logic rd_seen;

  typedef struct {
    logic        is_wr;
    logic [15:0] off;
    logic [63:0] data;
    logic [8:0]  tid;
  } vec_t;
  vec_t vecs[18];

  hc_csr_regfile dut (
    .clk(clk), .rst_n(rst_n),
    .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid),
    .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_wr_data(mmio_wr_data),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_tid(rd_rsp_tid), .rd_rsp_data(rd_rsp_data),
    .dsm_base(dsm_base), .buf_addr(buf_addr), .buf_size(buf_size),
    .acc_soft_reset(acc_soft_reset), .acc_start(acc_start),
    .acc_running(acc_running), .acc_done(acc_done)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  // driver tasks
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mmio_write(input logic [15:0] off, input logic [63:0] data);
    mmio_addr = {2'b00, off[15:2]};
    mmio_wr_data = data;
    mmio_wr_valid = 1'b1;
    @(posedge clk); #1;
    mmio_wr_valid = 1'b0;
  endtask

  task automatic mmio_read(input logic [15:0] off, input logic [8:0] tid, input logic [63:0] exp);
    mmio_addr = {2'b00, off[15:2]};
    mmio_tid = tid;
    mmio_rd_valid = 1'b1;
    exp_q.push_back({tid, exp});
    @(posedge clk); #1;
    mmio_rd_valid = 1'b0;
  endtask

  task automatic mmio_rw(input logic [15:0] off, input logic [63:0] data,
                         input logic [8:0] tid, input logic [63:0] exp);
    mmio_addr = {2'b00, off[15:2]};
    mmio_wr_data = data;
    mmio_tid = tid;
    mmio_wr_valid = 1'b1;
    mmio_rd_valid = 1'b1;
    exp_q.push_back({tid, exp});
    @(posedge clk); #1;
    mmio_wr_valid = 1'b0;
    mmio_rd_valid = 1'b0;
  endtask

  // scoreboard: a response must appear exactly one cycle after each accepted read
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_seen <= 1'b0;
    else        rd_seen <= mmio_rd_valid;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (rd_seen || rd_rsp_valid) begin
        n_compared++;
        if (rd_rsp_valid !== rd_seen) begin
          n_mismatched++;
          $display("FAIL rsp_timing: rd_rsp_valid=%b expected %b", rd_rsp_valid, rd_seen);
        end
      end
      if (rd_rsp_valid === 1'b1) begin
        n_compared++;
        if (exp_q.size() == 0) begin
          n_mismatched++;
          $display("FAIL rsp_unexpected: tid %h data %h with no read outstanding", rd_rsp_tid, rd_rsp_data);
        end else begin
          logic [72:0] e;
          e = exp_q.pop_front();
          if ({rd_rsp_tid, rd_rsp_data} !== e) begin
            n_mismatched++;
            $display("FAIL rsp_data: got tid %h data %h expected tid %h data %h",
                     rd_rsp_tid, rd_rsp_data, e[72:64], e[63:0]);
          end
        end
      end
    end
  end

  initial begin
    logic [63:0] st_run, st_done;

    vecs[0]  = '{1'b1, 16'h110, 64'h5555, 9'h000};
    vecs[1]  = '{1'b0, 16'h110, 64'h5555, 9'h001};
    vecs[2]  = '{1'b1, 16'h150, 64'h1234, 9'h000};
    vecs[3]  = '{1'b1, 16'h158, 64'd4096, 9'h000};
    vecs[4]  = '{1'b0, 16'h150, 64'h1234, 9'h002};
    vecs[5]  = '{1'b0, 16'h158, 64'h1000, 9'h003};
    vecs[6]  = '{1'b0, 16'h100, 64'h00C0_0000, 9'h004};
    vecs[7]  = '{1'b1, 16'h160, 64'hDEAD, 9'h000};
    vecs[8]  = '{1'b0, 16'h160, 64'h0, 9'h005};
    vecs[9]  = '{1'b1, 16'h154, 64'hBEEF, 9'h000};
    vecs[10] = '{1'b0, 16'h150, 64'h1234, 9'h006};
    vecs[11] = '{1'b1, 16'h120, 64'hFFFF_FFFF_FFFF_FFFF, 9'h000};
    vecs[12] = '{1'b0, 16'h120, 64'h0000_03FF_FFFF_FFFF, 9'h107};
    vecs[13] = '{1'b1, 16'h128, 64'hABCD_0000_1234_5678, 9'h000};
    vecs[14] = '{1'b0, 16'h128, 64'h1234_5678, 9'h108};
    vecs[15] = '{1'b0, 16'h118, 64'h0, 9'h1FF};
    vecs[16] = '{1'b1, 16'h100, 64'hFFFF, 9'h000};
    vecs[17] = '{1'b0, 16'h100, 64'h00C3_0000, 9'h0AA};

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    check("rst_soft_reset", 64'(acc_soft_reset), 64'd1);
    check("rst_start", 64'(acc_start), 64'd0);
    check("rst_running", 64'(acc_running), 64'd0);
    check("rst_rsp_valid", 64'(rd_rsp_valid), 64'd0);
    check("rst_rsp_tid", 64'(rd_rsp_tid), 64'd0);
    check("rst_rsp_data", rd_rsp_data, 64'd0);
    check("rst_dsm", dsm_base, 64'd0);
    for (int i = 0; i < NB; i++) begin
      check("rst_buf_addr", 64'(buf_addr[i*AW +: AW]), 64'd0);
      check("rst_buf_size", 64'(buf_size[i*SW +: SW]), 64'd0);
    end

    mmio_read(16'h100, 9'h055, 64'h0);
    check("status_rd_soft_reset", 64'(acc_soft_reset), 64'd1);

    for (int i = 0; i < 18; i++) begin
      if (vecs[i].is_wr) mmio_write(vecs[i].off, vecs[i].data);
      else               mmio_read(vecs[i].off, vecs[i].tid, vecs[i].data);
    end

    check("port_dsm", dsm_base, 64'h5555);
    check("port_buf_addr3", 64'(buf_addr[3*AW +: AW]), 64'h1234);
    check("port_buf_size3", 64'(buf_size[3*SW +: SW]), 64'd4096);
    check("port_buf_addr0", 64'(buf_addr[0 +: AW]), 64'h3FF_FFFF_FFFF);
    check("port_buf_size0", 64'(buf_size[0 +: SW]), 64'h1234_5678);
    check("port_buf_addr1", 64'(buf_addr[1*AW +: AW]), 64'h0);
    check("port_buf_size2", 64'(buf_size[2*SW +: SW]), 64'h0);

    // same-cycle write and read returns the old value
    mmio_rw(16'h110, 64'hAAAA, 9'h033, 64'h5555);
    mmio_read(16'h110, 9'h034, 64'hAAAA);
    check("rw_dsm_port", dsm_base, 64'hAAAA);

    mmio_write(16'h118, 64'h1);
    check("idle_soft_reset", 64'(acc_soft_reset), 64'd0);
    check("idle_running", 64'(acc_running), 64'd0);
`ifdef HC_CFG_CHECK_EN
    mmio_write(16'h118, 64'h3);
    check("rej_start", 64'(acc_start), 64'd0);
    check("rej_running", 64'(acc_running), 64'd0);
    mmio_read(16'h100, 9'h040, 64'h00C3_0009);
    mmio_write(16'h130, 64'h11);
    mmio_write(16'h138, 64'h22);
    mmio_write(16'h140, 64'h33);
    mmio_write(16'h148, 64'h44);
    st_run  = 64'h00FF_000A;
    st_done = 64'h00FF_000C;
`else
    st_run  = 64'h00C3_0002;
    st_done = 64'h00C3_0004;
`endif
    mmio_write(16'h118, 64'h3);
    check("run_start_1st", 64'(acc_start), 64'd1);
    check("run_running", 64'(acc_running), 64'd1);
    @(posedge clk); #1;
    check("run_start_2nd", 64'(acc_start), 64'd0);
    check("run_running_2nd", 64'(acc_running), 64'd1);
    mmio_read(16'h100, 9'h041, st_run);

    acc_done = 1'b1;
    @(posedge clk); #1;
    acc_done = 1'b0;
    check("done_running", 64'(acc_running), 64'd0);
    mmio_read(16'h100, 9'h042, st_done);

    mmio_write(16'h118, 64'h0);
    check("cmd0_soft_reset", 64'(acc_soft_reset), 64'd1);
    mmio_read(16'h100, 9'h043, 64'h0);
    check("retain_dsm", dsm_base, 64'hAAAA);
    check("retain_buf_addr3", 64'(buf_addr[3*AW +: AW]), 64'h1234);

    for (int i = 0; i < NB; i++) begin
      mmio_write(16'(16'h120 + 16 * i), 64'(16'h100 + i));
      mmio_write(16'(16'h128 + 16 * i), 64'(16'h40 * (i + 1)));
    end
    check("cfg_buf_size2", 64'(buf_size[2*SW +: SW]), 64'hC0);
    check("cfg_buf_addr1", 64'(buf_addr[1*AW +: AW]), 64'h101);

    mmio_write(16'h118, 64'h1);
    mmio_write(16'h118, 64'h3);
    check("run2_start", 64'(acc_start), 64'd1);

    // stop command and acc_done together: command wins
    acc_done = 1'b1;
    mmio_write(16'h118, 64'h7);
    acc_done = 1'b0;
    check("stop_running", 64'(acc_running), 64'd0);
    mmio_read(16'h100, 9'h044, 64'h00FF_0003);
    mmio_write(16'h118, 64'h5);
    mmio_write(16'h118, 64'h3);
    check("stop_no_start", 64'(acc_start), 64'd0);
    mmio_read(16'h100, 9'h045, 64'h00FF_0003);

    mmio_write(16'h118, 64'h1);
    mmio_write(16'h118, 64'h3);
    check("run3_running", 64'(acc_running), 64'd1);

    // async reset with a read response on the outputs
    mmio_read(16'h110, 9'h1AB, 64'hAAAA);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_running", 64'(acc_running), 64'd0);
    check("arst_soft_reset", 64'(acc_soft_reset), 64'd1);
    check("arst_rsp_valid", 64'(rd_rsp_valid), 64'd0);
    check("arst_rsp_data", rd_rsp_data, 64'd0);
    check("arst_dsm", dsm_base, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mmio_read(16'h100, 9'h077, 64'h0);
    check("post_rst_buf_addr1", 64'(buf_addr[1*AW +: AW]), 64'h0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
